// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: snoops CPU stores, queues bytes in a small
// FIFO and serializes them LSB first on tx, with a polled status word.
module uart_tx_mmio #(
  parameter int            n            = 16,
  parameter logic [n-1:0]  TXADDR       = 16'hFFF0,
  parameter logic [n-1:0]  CTLADDR      = 16'hFFF2,
  parameter int            CLKS_PER_BIT = 16,
  parameter int            DEPTH        = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memwrite,
  input  logic [n-1:0] dataadr,
  input  logic [n-1:0] writedata,
  output logic         tx,
  output logic [n-1:0] status
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [7:0]      mem_q [DEPTH];
  logic [PW-1:0]   rptr_q, wptr_q;
  logic [CW-1:0]   count_q;
  logic            ovf_q;
  logic            push_s, clr_s, pop_s, accept_s, bit_end_s;
  logic            fifo_empty_s, fifo_full_s;
  logic            unused_s;

  assign push_s       = memwrite && (dataadr == TXADDR);
  assign clr_s        = memwrite && (dataadr == CTLADDR);
  assign fifo_empty_s = (count_q == '0);
  assign fifo_full_s  = (count_q == DEPTH_C);
  // A full FIFO still accepts a byte when the serializer frees a slot on the same edge.
  assign accept_s     = push_s && (!fifo_full_s || pop_s);
  assign bit_end_s    = (baud_q == BAUD_LAST);
  assign unused_s     = ^writedata[n-1:8];
  assign tx           = tx_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    pop_s   = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = mem_q[rptr_q];
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          baud_d  = '0;
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          baud_d = '0;
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            shift_d = mem_q[rptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
    // tx is registered from the next state so the line changes exactly at state entry.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept_s) begin
        wptr_q <= wptr_q + PW'(1);
      end
      if (pop_s) begin
        rptr_q <= rptr_q + PW'(1);
      end
      if (accept_s && !pop_s) begin
        count_q <= count_q + CW'(1);
      end else if (pop_s && !accept_s) begin
        count_q <= count_q - CW'(1);
      end
      if (push_s && !accept_s) begin
        ovf_q <= 1'b1;
      end else if (clr_s) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[wptr_q] <= writedata[7:0];
    end
  end

  always_comb begin
    status    = '0;
    status[0] = fifo_full_s;
    status[1] = fifo_empty_s;
    status[2] = (state_q != IDLE);
    status[3] = ovf_q;
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the CPU data bus, downstream of the `computer` top. It snoops the `memwrite`, `dataadr` and `writedata` outputs that also drive `dmem`. A store to the TX address queues one byte in a small FIFO. A serializer drains the FIFO as 8N1 frames on `tx`. A combinational status word lets a testbench or a future readdata mux poll full, empty, busy and overflow.

## Interface
- `n`, 16: data/address bus width; matches `computer`.
- `TXADDR`, 16'hFFF0: store address that enqueues `writedata[7:0]`.
- `CTLADDR`, 16'hFFF2: store address that clears the sticky overflow flag; `writedata` is ignored.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; minimum 2.
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.

- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `memwrite`  in  1: CPU store strobe, sampled on the rising edge of `clk`.
- `dataadr`  in  n: CPU store address.
- `writedata`  in  n: CPU store data; bits [n-1:8] are ignored.
- `tx`  out  1: serial line; idles high; registered output.
- `status`  out  n: combinational status word.
  - bit0 = FIFO full.
  - bit1 = FIFO empty.
  - bit2 = busy (FSM not in IDLE).
  - bit3 = overflow (sticky).
  - all other bits 0.

## Operation
- Reset values (`reset`=0): `tx`=1; FIFO count 0; FSM in IDLE; overflow flag 0; `status`=16'h0002.
- Push: occurs when `memwrite`=1 and `dataadr`==`TXADDR` on a clock edge.
  - Accepted if count<`DEPTH`, or if count==`DEPTH` and a pop occurs on the same edge.
  - Otherwise the byte is dropped and overflow is set to 1.
- Clear: `memwrite`=1 with `dataadr`==`CTLADDR` clears overflow. If an overflow and a clear happen on the same edge, overflow ends at 1 (set wins).
- A store to any other address has no effect.
- FSM states and transitions:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for `CLKS_PER_BIT` cycles, then shift right. Advance the index; after index 7 go to STOP. Bits go out LSB first.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. At the end:
    - if the FIFO is non-empty, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Baud counter: counts 0..`CLKS_PER_BIT`-1 and is reset to 0 on every state entry. Its width is clog2(`CLKS_PER_BIT`).
- FIFO: circular buffer with read/write pointers of width clog2(`DEPTH`) that wrap modulo `DEPTH`. A separate count register of width clog2(`DEPTH`)+1 distinguishes full from empty.
- Push and pop on the same edge: count is unchanged and both pointers advance.
- Reset mid-frame: `tx` returns to 1 immediately (asynchronous). The partial frame and all queued bytes are discarded.

## Timing
- Store at edge k updates count and `status` after edge k.
- IDLE pops at edge k+1, and `tx` falls to 0 after edge k+1. The first-byte latency from store to start bit is 1 cycle.
- One frame occupies exactly 10·`CLKS_PER_BIT` cycles.
- Back-to-back frames: the next start bit begins the cycle after the last stop-bit cycle.
- The FIFO slot is freed at the pop edge, not at the end of the frame.
- `status` is combinational from registered state only, with no path from bus inputs.
- `tx` changes only on clock edges, except when driven by reset.

## Test plan
- Reset test: hold `reset`=0 for 3 cycles, then release. Required: `tx`=1, `status`=16'h0002, and `tx` stays 1 for 50 cycles with no stores.
- Single byte (`CLKS_PER_BIT`=4): store 16'h12A5 to 16'hFFF0.
  - Start bit begins 1 cycle later.
  - `tx` carries, 4 cycles each: 0,1,0,1,0,0,1,0,1,1.
  - Then `tx` stays 1; busy=0 after 40 cycles.
- Back-to-back: store 8'h00 then 8'hFF on consecutive cycles. Required: 80 contiguous cycles of frames with no idle high gap between stop bit 1 and the second start bit; `status`=16'h0002 at the end.
- Overflow (`DEPTH`=4): store 6 bytes on consecutive cycles.
  - The first pops at once, 4 are queued, and the sixth is dropped.
  - Required: full=1 and overflow=1.
  - Exactly 5 frames are transmitted.
  - A store to 16'hFFF2 clears overflow only.
- Address filter: stores to 16'hFFEE and 16'h0010 leave `status` unchanged and `tx` idle.
- Mid-frame reset: assert `reset` during DATA bit 3 of the second of two queued bytes. Required: `tx`=1 immediately, `status`=16'h0002, and no frame after release.
